i2c_eeprom_slave: RTL and testbench
===================================

I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 SHALL have parameter P_DEV_SEL, default 3'd3, giving the A2..A1..A0 bits of the 7-bit device address {4'b1010, P_DEV_SEL}.
REQ-002 SHALL have parameter P_MEM_AW, default 8, giving the memory address width; depth is 2^P_MEM_AW bytes.
REQ-003 SHALL have parameter P_PAGE_AW, default 3, giving the page address width; page size is 8 bytes.
REQ-004 clk  input  1  system clock; the block SHALL be single-clock on clk, with clk at least 16x the SCL frequency.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_i2c_scl  input  1  I2C clock driven by the master.
REQ-007 io_i2c_sda  inout  1  open-drain data line; the block SHALL only drive 1'b0 or 1'bz.
REQ-008 o_wr_valid  output  1  one-clk pulse when a byte is committed to memory.
REQ-009 o_wr_addr  output  16  word address of the committed byte.
REQ-010 o_wr_data  output  8  data of the committed byte.
REQ-011 o_rd_valid  output  1  one-clk pulse when a read byte is loaded for transmission.
REQ-012 o_busy  output  1  high from an addressed (ACKed) device byte until STOP, NACK-idle or reset.

Function
REQ-013 SCL and SDA SHALL each pass through a 2-flop synchronizer; all edge and condition detection SHALL use the synchronized values.
REQ-014 START (SDA falling while SCL high) SHALL force state DEV_ADDR from any state and clear the bit counter; a repeated START SHALL behave identically.
REQ-015 STOP (SDA rising while SCL high) SHALL force IDLE from any state and release SDA.
REQ-016 Received bits SHALL be sampled MSB-first on synchronized SCL rising edges; SDA drive changes SHALL occur only on the clk following a synchronized SCL falling edge.
REQ-017 States SHALL be IDLE, DEV_ADDR, DEV_ACK, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-018 DEV_ADDR: after 8 bits, a matching address SHALL go to DEV_ACK; a mismatch SHALL release SDA (NACK) and go to WAIT_STOP.
REQ-019 ACK timing: on the SCL falling edge after bit 8, the block SHALL drive SDA low, and SHALL release it on the following SCL falling edge.
REQ-020 DEV_ACK exit: with R/W=0 the block SHALL go to ADDR_HI; with R/W=1 it SHALL go to RD_DATA using the current internal pointer (current-address read).
REQ-021 ADDR_HI then ADDR_LO SHALL each be ACKed and SHALL load the 16-bit pointer; only pointer bits [P_MEM_AW-1:0] SHALL index memory, and o_wr_addr SHALL report the full 16-bit pointer.
REQ-022 WR_DATA: each received byte SHALL be written to mem[pointer], pulse o_wr_valid, and be ACKed (WR_ACK); the pointer SHALL then increment only in bits [P_PAGE_AW-1:0], wrapping within the page.
REQ-023 An address-only write terminated by a repeated START SHALL leave the pointer set, with no memory write (dummy write).
REQ-024 RD_DATA: the block SHALL load the shift register with mem[pointer] and pulse o_rd_valid; it SHALL drive the MSB after the ACK-release falling edge and shift one bit per SCL falling edge, driving SDA low for 0 and releasing it for 1.
REQ-025 After 8 read bits the block SHALL release SDA and sample the master's bit on the 9th SCL rising edge: ACK (0) SHALL increment the pointer across the full memory with wrap and load the next byte; NACK (1) SHALL go to WAIT_STOP.
REQ-026 WAIT_STOP SHALL keep SDA released and ignore bits until START or STOP.
REQ-027 Memory SHALL NOT be cleared by reset; its contents after power-up are undefined.

Reset
REQ-028 On rst: state SHALL be IDLE, SDA SHALL be released, o_wr_valid=0, o_rd_valid=0, o_busy=0, o_wr_addr=0, o_wr_data=0, pointer=0, and synchronizers SHALL be preset to 1.
REQ-029 rst asserted mid-transfer SHALL release SDA immediately (asynchronously), and the block SHALL wait for the next START.

Verification
REQ-030 Page write: START, 0xA6, 0x00, 0x00, 0x11..0x18, STOP -> 11 ACKs, 8 o_wr_valid pulses at addr 0..7 with data 0x11..0x18, o_busy low after STOP.
REQ-031 Random read: START, 0xA6, 0x00, 0x00, rSTART, 0xA7, master ACKs 7 bytes then NACKs -> SDA returns 0x11..0x18 and the block releases SDA after the NACK.
REQ-032 Page wrap: write 0xAA, 0xBB, 0xCC starting at addr 0x0006 -> writes land at 0x06, 0x07, 0x00.
REQ-033 Wrong device: START, 0xA0 -> SDA released on the 9th clock, no ACK, o_busy stays 0, and subsequent bytes are ignored until STOP.
REQ-034 Current-address read after a read ending at 0x07 (ACK) -> the next START, 0xA7 returns mem[0x08]; a read ACKed at 0xFF wraps to 0x00.
REQ-035 rst pulse during the 4th bit of a read byte -> SDA immediately Z, o_busy=0, pointer=0, and the next transaction is handled normally.

Source files
------------

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C EEPROM-style slave with 16-bit word pointer, page-wrapped writes and sequential reads.
// SDA is open-drain: sda_oe pulls the line low, otherwise it is released.
module i2c_eeprom_slave #(
  parameter logic [2:0] P_DEV_SEL = 3'd3,
  parameter int P_MEM_AW = 8,
  parameter int P_PAGE_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_i2c_scl,
  inout  wire         io_i2c_sda,
  output logic        o_wr_valid,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_rd_valid,
  output logic        o_busy
);
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;
  localparam logic [15:0] MEM_MASK = 16'((32'd1 << P_MEM_AW) - 1);
  localparam logic [15:0] PAGE_MASK = 16'((32'd1 << P_PAGE_AW) - 1);
  state_t state, state_n;
  logic [2:0] scl_s, sda_s;
  logic scl, scl_d, sda, sda_d;
  logic scl_rise, scl_fall, start, stop, rx, byte_done, match, load;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, rd_byte;
  logic [15:0] ptr;
  logic rw, sda_oe;
  logic [7:0] mem [2**P_MEM_AW];
  // bits [1] are the synchronized lines, bits [2] their previous value for edge detection
  assign scl = scl_s[1];
  assign scl_d = scl_s[2];
  assign sda = sda_s[1];
  assign sda_d = sda_s[2];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start = scl & scl_d & sda_d & ~sda;
  assign stop = scl & scl_d & ~sda_d & sda;
  assign rx = state inside {DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA};
  assign byte_done = rx & scl_fall & (bit_cnt == 4'd8);
  assign match = shreg[7:1] == {4'b1010, P_DEV_SEL};
  assign load = (state_n == RD_DATA) & (state != RD_DATA);
  assign rd_byte = mem[ptr[P_MEM_AW-1:0]];
  assign io_i2c_sda = sda_oe ? 1'b0 : 1'bz;
  always_comb begin
    state_n = state;
    if (start) state_n = DEV_ADDR;
    else if (stop) state_n = IDLE;
    else case (state)
      DEV_ADDR: if (byte_done) state_n = match ? DEV_ACK : WAIT_STOP;
      DEV_ACK:  if (scl_fall) state_n = rw ? RD_DATA : ADDR_HI;
      ADDR_HI:  if (byte_done) state_n = ACK_HI;
      ACK_HI:   if (scl_fall) state_n = ADDR_LO;
      ADDR_LO:  if (byte_done) state_n = ACK_LO;
      WR_DATA:  if (byte_done) state_n = WR_ACK;
      ACK_LO, WR_ACK: if (scl_fall) state_n = WR_DATA;
      RD_DATA:  if (scl_fall && bit_cnt == 4'd7) state_n = RD_ACK;
      RD_ACK:   if (scl_rise && sda) state_n = WAIT_STOP;
                else if (scl_fall) state_n = RD_DATA;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      scl_s <= '1;
      sda_s <= '1;
      bit_cnt <= '0;
      shreg <= '0;
      ptr <= '0;
      rw <= 1'b0;
      sda_oe <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_rd_valid <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state <= state_n;
      scl_s <= {scl_s[1:0], i_i2c_scl};
      sda_s <= {sda_s[1:0], io_i2c_sda};
      o_wr_valid <= 1'b0;
      o_rd_valid <= 1'b0;
      if (start || stop) begin
        bit_cnt <= '0;
        sda_oe <= 1'b0;
        if (stop) o_busy <= 1'b0;
      end else if (rx && scl_rise) begin
        shreg <= {shreg[6:0], sda};
        bit_cnt <= bit_cnt + 4'd1;
      end else if (byte_done) begin
        bit_cnt <= '0;
        sda_oe <= state != DEV_ADDR || match;
        if (state == DEV_ADDR) begin
          rw <= shreg[0];
          o_busy <= match;
        end
        if (state == ADDR_HI) ptr[15:8] <= shreg;
        if (state == ADDR_LO) ptr[7:0] <= shreg;
        if (state == WR_DATA) begin
          o_wr_valid <= 1'b1;
          o_wr_addr <= ptr;
          o_wr_data <= shreg;
          ptr <= (ptr & ~PAGE_MASK) | ((ptr + 16'd1) & PAGE_MASK);
        end
      end else if (load) begin
        shreg <= rd_byte;
        sda_oe <= ~rd_byte[7];
        o_rd_valid <= 1'b1;
        bit_cnt <= '0;
      end else if (state == RD_DATA && scl_fall) begin
        shreg <= {shreg[6:0], 1'b0};
        sda_oe <= bit_cnt != 4'd7 && !shreg[6];
        bit_cnt <= bit_cnt + 4'd1;
      end else if (state == RD_ACK && scl_rise) begin
        if (sda) o_busy <= 1'b0;
        else ptr <= (ptr & ~MEM_MASK) | ((ptr + 16'd1) & MEM_MASK);
      end else if (scl_fall && state inside {DEV_ACK, ACK_HI, ACK_LO, WR_ACK})
        sda_oe <= 1'b0;
    end
  always_ff @(posedge clk)
    if (byte_done && state == WR_DATA) mem[ptr[P_MEM_AW-1:0]] <= shreg;
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: directed I2C master transactions against i2c_eeprom_slave with hand-computed expectations.
module tb_i2c_eeprom_slave;
  localparam int Q = 100;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_low = 1'b0;
  wire sda;
  logic wr_valid, rd_valid, busy;
  logic [15:0] wr_addr;
  logic [7:0] wr_data;
  int tests = 0, fails = 0, rd_cnt = 0;
  logic [15:0] wa [$];
  logic [7:0] wd [$];
  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  i2c_eeprom_slave dut (
    .clk(clk), .rst(rst), .i_i2c_scl(scl), .io_i2c_sda(sda),
    .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_valid(rd_valid), .o_busy(busy)
  );
  always @(negedge clk) begin
    if (wr_valid) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (rd_valid) rd_cnt++;
  end
  task automatic start_c;
    sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q sda_low = 1'b1;
    #Q scl = 1'b0;
  endtask
  task automatic stop_c;
    sda_low = 1'b1;
    #Q scl = 1'b1;
    #Q sda_low = 1'b0;
    #Q;
  endtask
  task automatic send_bit(input logic b);
    #Q sda_low = !b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    #Q sda_low = 1'b0;
    #Q scl = 1'b1;
    #Q ack = (sda === 1'b0);
    #Q scl = 1'b0;
  endtask
  task automatic recv_byte(input logic ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      #Q sda_low = 1'b0;
      #Q scl = 1'b1;
      #Q d[i] = (sda === 1'b1);
      #Q scl = 1'b0;
    end
    send_bit(!ack);
  endtask
  task automatic test_reset;
    #23;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (wr_valid !== 1'b0 || rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got wr=%b rd=%b expected 0 0", wr_valid, rd_valid); end
    tests++; if (wr_addr !== 16'h0000 || wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_bus: got %h/%h expected 0000/00", wr_addr, wr_data); end
    tests++; if (sda !== 1'b1) begin fails++; $display("FAIL reset_sda: got %b expected 1", sda); end
    #30 rst = 1'b0;
    #Q;
  endtask
  task automatic test_page_write;
    logic ack;
    logic [7:0] bytes [11];
    bytes[0] = 8'hA6; bytes[1] = 8'h00; bytes[2] = 8'h00;
    for (int i = 0; i < 8; i++) bytes[3+i] = 8'h11 + 8'(i);
    wa.delete(); wd.delete();
    start_c();
    for (int i = 0; i < 11; i++) begin
      send_byte(bytes[i], ack);
      tests++; if (ack !== 1'b1) begin fails++; $display("FAIL pw_ack%0d: got nack expected ack", i); end
      if (i == 0) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pw_busy: got %b expected 1", busy); end
      end
    end
    stop_c();
    #Q;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL pw_busy_stop: got %b expected 0", busy); end
    tests++; if (wa.size() != 8) begin fails++; $display("FAIL pw_count: got %0d expected 8", wa.size()); end
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      tests++; if (wa[i] !== 16'(i) || wd[i] !== 8'h11 + 8'(i)) begin fails++; $display("FAIL pw_wr%0d: got %h/%h expected %h/%h", i, wa[i], wd[i], 16'(i), 8'h11 + 8'(i)); end
    end
  endtask
  task automatic test_random_read;
    logic ack;
    logic [7:0] d;
    int rd0;
    start_c();
    send_byte(8'hA6, ack);
    send_byte(8'h00, ack);
    send_byte(8'h00, ack);
    start_c();
    send_byte(8'hA7, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL rr_dev_ack: got nack expected ack"); end
    rd0 = rd_cnt;
    for (int i = 0; i < 8; i++) begin
      recv_byte(i < 7, d);
      tests++; if (d !== 8'h11 + 8'(i)) begin fails++; $display("FAIL rr_data%0d: got %h expected %h", i, d, 8'h11 + 8'(i)); end
    end
    #Q;
    tests++; if (sda !== 1'b1) begin fails++; $display("FAIL rr_release: got %b expected 1", sda); end
    tests++; if (rd_cnt - rd0 != 8) begin fails++; $display("FAIL rr_rd_valid: got %0d expected 8", rd_cnt - rd0); end
    stop_c();
  endtask
  task automatic test_current_read;
    logic ack;
    logic [7:0] d;
    wa.delete(); wd.delete();
    start_c(); send_byte(8'hA6, ack); send_byte(8'h01, ack); send_byte(8'h08, ack); send_byte(8'hC3, ack); stop_c();
    start_c(); send_byte(8'hA6, ack); send_byte(8'h00, ack); send_byte(8'hFF, ack); send_byte(8'h9E, ack); stop_c();
    #Q;
    tests++; if (wa.size() != 2 || wa[0] !== 16'h0108 || wd[0] !== 8'hC3 || wa[1] !== 16'h00FF || wd[1] !== 8'h9E) begin
      fails++; $display("FAIL cr_writes: got %0d writes first %h/%h expected 0108/C3 then 00FF/9E", wa.size(), wa.size() > 0 ? wa[0] : 16'hxxxx, wd.size() > 0 ? wd[0] : 8'hxx);
    end
    start_c(); send_byte(8'hA6, ack); send_byte(8'h00, ack); send_byte(8'h07, ack);
    start_c(); send_byte(8'hA7, ack);
    recv_byte(1'b1, d);
    tests++; if (d !== 8'h18) begin fails++; $display("FAIL cr_at07: got %h expected 18", d); end
    stop_c();
    start_c(); send_byte(8'hA7, ack);
    recv_byte(1'b0, d);
    tests++; if (d !== 8'hC3) begin fails++; $display("FAIL cr_current08: got %h expected C3", d); end
    stop_c();
    start_c(); send_byte(8'hA6, ack); send_byte(8'h00, ack); send_byte(8'hFF, ack);
    start_c(); send_byte(8'hA7, ack);
    recv_byte(1'b1, d);
    tests++; if (d !== 8'h9E) begin fails++; $display("FAIL cr_atFF: got %h expected 9E", d); end
    recv_byte(1'b0, d);
    tests++; if (d !== 8'h11) begin fails++; $display("FAIL cr_wrap00: got %h expected 11", d); end
    stop_c();
  endtask
  task automatic test_page_wrap;
    logic ack;
    wa.delete(); wd.delete();
    start_c(); send_byte(8'hA6, ack); send_byte(8'h00, ack); send_byte(8'h06, ack);
    send_byte(8'hAA, ack); send_byte(8'hBB, ack); send_byte(8'hCC, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL wrap_ack: got nack expected ack"); end
    stop_c();
    #Q;
    tests++; if (wa.size() != 3 || wa[0] !== 16'h0006 || wa[1] !== 16'h0007 || wa[2] !== 16'h0000) begin
      fails++; $display("FAIL wrap_addr: got %0d writes expected 0006 0007 0000", wa.size());
    end
    tests++; if (wd.size() != 3 || wd[0] !== 8'hAA || wd[1] !== 8'hBB || wd[2] !== 8'hCC) begin
      fails++; $display("FAIL wrap_data: got %0d writes expected AA BB CC", wd.size());
    end
  endtask
  task automatic test_wrong_device;
    logic ack;
    wa.delete(); wd.delete();
    start_c();
    send_byte(8'hA0, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wd_nack: got ack expected nack"); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wd_busy: got %b expected 0", busy); end
    send_byte(8'hA6, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wd_ignore1: got ack expected nack"); end
    send_byte(8'h00, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wd_ignore2: got ack expected nack"); end
    stop_c();
    #Q;
    tests++; if (wa.size() != 0 || busy !== 1'b0) begin fails++; $display("FAIL wd_side: got %0d writes busy=%b expected 0 writes busy=0", wa.size(), busy); end
  endtask
  task automatic test_reset_mid_read;
    logic ack;
    logic [7:0] d;
    start_c(); send_byte(8'hA6, ack); send_byte(8'h00, ack); send_byte(8'h06, ack);
    start_c(); send_byte(8'hA7, ack);
    for (int i = 0; i < 3; i++) begin
      #Q sda_low = 1'b0;
      #Q scl = 1'b1;
      #(2*Q) scl = 1'b0;
    end
    #Q;
    #Q scl = 1'b1;
    #Q;
    tests++; if (sda !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL rmr_bit4: got sda=%b busy=%b expected 0 1", sda, busy); end
    rst = 1'b1;
    #1;
    tests++; if (sda !== 1'b1) begin fails++; $display("FAIL rmr_sda_async: got %b expected 1", sda); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmr_busy: got %b expected 0", busy); end
    #30 rst = 1'b0;
    #Q;
    start_c(); send_byte(8'hA7, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL rmr_after_ack: got nack expected ack"); end
    recv_byte(1'b0, d);
    tests++; if (d !== 8'hCC) begin fails++; $display("FAIL rmr_ptr0: got %h expected CC", d); end
    stop_c();
  endtask
  initial begin
    test_reset();
    test_page_write();
    test_random_read();
    test_current_read();
    test_page_wrap();
    test_wrong_device();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
